// File: rtl/floo_vc_router_switch_buffered_pkg.sv
// Shared types, routing enums and connectivity-mask generator for the buffered VC router switch.
package floo_vc_router_switch_buffered_pkg;

    typedef enum logic [2:0] {
        North = 3'd0,
        East  = 3'd1,
        South = 3'd2,
        West  = 3'd3,
        Eject = 3'd4
    } route_direction_e;

    typedef enum logic [1:0] {
        XYRouting     = 2'd0,
        IdTable       = 2'd1,
        SourceRouting = 2'd2
    } route_algo_e;

    localparam int unsigned MaxPorts     = 8;
    localparam int unsigned OwnerWidth   = $clog2(MaxPorts);
    localparam int unsigned PayloadWidth = 16;
    localparam int unsigned RobIdxWidth  = 4;
    localparam int unsigned IdWidth      = 4;
    localparam int unsigned PortIdWidth  = 3;
    localparam int unsigned AxiChWidth   = 3;

    typedef logic [OwnerWidth-1:0]   owner_idx_t;
    typedef logic [PayloadWidth-1:0] flit_payload_t;

    typedef struct packed {
        logic                   rob_req;
        logic [RobIdxWidth-1:0] rob_idx;
        logic [IdWidth-1:0]     dst_id;
        logic [PortIdWidth-1:0] dst_port_id;
        logic [IdWidth-1:0]     src_id;
        logic                   last;
        logic                   atop;
        logic [AxiChWidth-1:0]  axi_ch;
    } hdr_t;

    typedef struct packed {
        hdr_t          hdr;
        flit_payload_t payload;
    } flit_t;

    localparam int unsigned DataLength = $bits(flit_payload_t);

    // Indexed [inport][outport]; 1 = inport may drive outport.
    typedef logic [MaxPorts-1:0][MaxPorts-1:0] conn_mask_t;

    // No U-turns; XY routing additionally forbids turning from the Y axis onto the X axis.
    function automatic conn_mask_t gen_conn_mask(input route_algo_e route_algo,
                                                 input int unsigned num_ports);
        conn_mask_t mask;
        mask = '0;
        for (int unsigned i = 0; i < MaxPorts; i++) begin
            for (int unsigned o = 0; o < MaxPorts; o++) begin
                if ((i < num_ports) && (o < num_ports) && (i != o)) begin
                    mask[i][o] = 1'b1;
                end
            end
        end
        if (route_algo == XYRouting) begin
            mask[North][East] = 1'b0;
            mask[North][West] = 1'b0;
            mask[South][East] = 1'b0;
            mask[South][West] = 1'b0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/floo_vc_router_switch_buffered_out_stage.sv
// Per-outport stage: select legality, wormhole lock, elastic buffer and sticky error flag.
module floo_vc_router_switch_buffered_out_stage
    import floo_vc_router_switch_buffered_pkg::*;
#(
    parameter int unsigned         NumPorts = 5,
    parameter int unsigned         Depth    = 2,
    parameter logic [NumPorts-1:0] ConnCol  = '1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  flit_t               flit_i,
    input  logic [NumPorts-1:0] sel_i,
    input  logic                valid_i,
    output logic                ready_o,
    output flit_t               data_o,
    output logic                valid_o,
    input  logic                ready_i,
    input  logic                clr_err_i,
    output logic                err_o
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0] state_q, state_d;
    owner_idx_t owner_q, owner_d;
    owner_idx_t sel_idx;
    logic       sel_onehot, sel_legal, lock_ok;
    logic       accept, push, err_set;
    logic       err_q, err_d;

    // Encode the one-hot inport select into an owner index.
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (sel_i[i]) begin
                sel_idx = owner_idx_t'(i);
            end
        end
    end

    assign sel_onehot = (sel_i != '0) && ((sel_i & (sel_i - NumPorts'(1))) == '0);
    assign sel_legal  = sel_onehot && ((sel_i & ConnCol) != '0);
    assign lock_ok    = (state_q == StIdle) || (owner_q == sel_idx);
    assign accept     = valid_i && ready_o;
    assign push       = accept && sel_legal && lock_ok;
    assign err_set    = accept && !(sel_legal && lock_ok);

    // Wormhole lock next-state: a multi-flit packet owns the outport until its last flit.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            StIdle: begin
                if (push && !flit_i.hdr.last) begin
                    state_d = StLocked;
                    owner_d = sel_idx;
                end
            end
            StLocked: begin
                if (push && flit_i.hdr.last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new error takes priority over a coincident clear.
    assign err_d = err_set || (err_q && !clr_err_i);
    assign err_o = err_q;

    // Lock and error state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    if (Depth == 0) begin : gen_bypass
        assign ready_o = ready_i;
        assign valid_o = valid_i && sel_legal && lock_ok;
        assign data_o  = flit_i;
    end else begin : gen_fifo
        localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
        localparam int unsigned CntW = $clog2(Depth + 1);

        flit_t           mem_q [Depth];
        logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            full, empty, pop;

        assign full    = (cnt_q == CntW'(Depth));
        assign empty   = (cnt_q == '0);
        assign ready_o = !full;
        assign valid_o = !empty;
        assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
        assign pop     = valid_o && ready_i;

        // Pointer and occupancy update; pointers wrap at Depth.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!push && pop) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end

        // FIFO control registers.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // FIFO storage; contents are masked by the empty flag so no reset is needed.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= flit_i;
            end
        end
    end

endmodule

// File: rtl/floo_vc_router_switch_buffered.sv
// VC router crossbar: per-inport VC mux, header/payload crossbar and per-outport buffered stages.
module floo_vc_router_switch_buffered
    import floo_vc_router_switch_buffered_pkg::*;
#(
    parameter int unsigned NumPorts     = 5,
    parameter int unsigned NumVCMax     = 4,
    parameter int unsigned OutFifoDepth = 2,
    parameter route_algo_e RouteAlgo    = XYRouting
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  flit_payload_t [NumPorts-1:0][NumVCMax-1:0]  vc_data_head_i,
    input  hdr_t          [NumPorts-1:0]                ctrl_head_per_inport_i,
    input  logic          [NumPorts-1:0][NumVCMax-1:0]  read_vc_id_oh_i,
    input  logic          [NumPorts-1:0][NumPorts-1:0]  inport_id_oh_per_output_i,
    input  logic          [NumPorts-1:0]                valid_per_output_i,
    output logic          [NumPorts-1:0]                ready_per_output_o,
    output flit_t         [NumPorts-1:0]                data_o,
    output logic          [NumPorts-1:0]                valid_o,
    input  logic          [NumPorts-1:0]                ready_i,
    input  logic                                        clr_err_i,
    output logic          [NumPorts-1:0]                err_o
);

    localparam conn_mask_t ConnMask = gen_conn_mask(RouteAlgo, NumPorts);

    // Column of the connectivity mask: which inports may drive outport o.
    function automatic logic [NumPorts-1:0] conn_col(input int unsigned o);
        logic [NumPorts-1:0] col;
        col = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            col[i] = ConnMask[i][o];
        end
        return col;
    endfunction

    flit_payload_t [NumPorts-1:0] inport_payload;
    flit_t         [NumPorts-1:0] xbar_flit;

    // Per-inport AND-OR mux over the one-hot VC select.
    always_comb begin
        inport_payload = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            for (int unsigned v = 0; v < NumVCMax; v++) begin
                if (read_vc_id_oh_i[p][v]) begin
                    inport_payload[p] = inport_payload[p] | vc_data_head_i[p][v];
                end
            end
        end
    end

    // Crossbar: each outport gathers header and payload of its selected inport.
    always_comb begin
        xbar_flit = '0;
        for (int unsigned o = 0; o < NumPorts; o++) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (inport_id_oh_per_output_i[o][i]) begin
                    xbar_flit[o] = xbar_flit[o] | {ctrl_head_per_inport_i[i], inport_payload[i]};
                end
            end
        end
    end

    for (genvar o = 0; o < NumPorts; o++) begin : gen_out
        floo_vc_router_switch_buffered_out_stage #(
            .NumPorts (NumPorts),
            .Depth    (OutFifoDepth),
            .ConnCol  (conn_col(o))
        ) i_out_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flit_i    (xbar_flit[o]),
            .sel_i     (inport_id_oh_per_output_i[o]),
            .valid_i   (valid_per_output_i[o]),
            .ready_o   (ready_per_output_o[o]),
            .data_o    (data_o[o]),
            .valid_o   (valid_o[o]),
            .ready_i   (ready_i[o]),
            .clr_err_i (clr_err_i),
            .err_o     (err_o[o])
        );
    end

endmodule

// File: doc/floo_vc_router_switch_buffered.md
Name: floo_vc_router_switch_buffered

Overview:
- Next-generation VC router crossbar: selects the head flit per inport from the chosen VC and routes it to outports per allocator one-hot selects.
- Adds a per-outport elastic buffer of parametrisable depth with valid/ready handshake.
- Adds a wormhole lock FSM per outport, a parametrised connectivity mask and sticky error reporting for illegal selects.
- Sits between the VC allocator / switch allocator and the router output links.

Parameters:
- NumPorts, 5, number of router ports (N,E,S,W,L0..).
- NumVCMax, 4, max VCs per inport; inports with fewer VCs tie unused lanes to 0.
- OutFifoDepth, 2, per-outport buffer depth; legal 0..4; 0 = combinational passthrough.
- RouteAlgo, XYRouting, selects the default connectivity mask.
- ConnMask, derived from RouteAlgo, [NumPorts][NumPorts] bit, 1 = inport may drive outport. Diagonal is always 0. XY additionally clears N/S -> E/W.
- flit_t / flit_payload_t / hdr_t, logic, flit, payload and header types; DataLength = $bits(flit_payload_t).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- vc_data_head_i  in  [NumPorts][NumVCMax] flit_payload_t  head payload of every VC.
- ctrl_head_per_inport_i  in  [NumPorts] hdr_t  header of the selected head flit per inport.
- read_vc_id_oh_i  in  [NumPorts][NumVCMax]  one-hot VC select per inport.
- inport_id_oh_per_output_i  in  [NumPorts][NumPorts]  one-hot inport select per outport.
- valid_per_output_i  in  [NumPorts]  allocator transfer request per outport.
- ready_per_output_o  out  [NumPorts]  outport stage can accept.
- data_o  out  [NumPorts] flit_t  output flits.
- valid_o  out  [NumPorts]  output valid.
- ready_i  in  [NumPorts]  downstream ready.
- clr_err_i  in  1  clears error flags.
- err_o  out  [NumPorts]  sticky select/lock error per outport.

Behaviour:
- Datapath: per inport, payload = mux over read_vc_id_oh_i. Per outport, flit = selected inport payload plus the full hdr copied from ctrl_head_per_inport_i. Fields copied: rob_req, rob_idx, dst_id, dst_port_id, src_id, last, atop, axi_ch.
- Accept: at outport o, the transfer happens when valid_per_output_i[o] && ready_per_output_o[o].
- Illegal select at accept is any of: select is 0, select is multi-hot, or select hits a ConnMask=0 entry. On illegal select: flit dropped, err_o[o] set next cycle, lock state unchanged.
- Lock FSM per outport, states IDLE and LOCKED(owner):
  - IDLE + accepted legal flit with last=0 -> LOCKED(owner = that inport).
  - IDLE + last=1 -> stay IDLE (single-flit packet).
  - LOCKED + accepted flit from owner with last=1 -> IDLE.
  - LOCKED + flit from owner with last=0 -> stay LOCKED.
  - LOCKED + flit from a non-owner -> flit dropped, err_o set, stay LOCKED.
- Buffer, OutFifoDepth >= 1:
  - FIFO per outport. ready_per_output_o = !full; no pop-through when full.
  - valid_o = !empty; data_o = FIFO head, '0 when empty.
  - Latency: accepted flit appears on data_o one cycle later.
  - Push and pop may occur in the same cycle; count unchanged.
  - Pointers wrap modulo depth.
  - data_o stable while valid_o && !ready_i.
- Buffer, OutFifoDepth = 0: valid_o = valid_per_output_i & legal & lock-ok; ready_per_output_o = ready_i; data_o combinational; zero latency.
- Errors: err_o sticky until clr_err_i. If clr_err_i coincides with a new error, set wins.
- Reset: FIFOs emptied, valid_o=0, data_o='0, lock FSMs IDLE, err_o=0, ready_per_output_o=1 when depth>=1. Reset mid-packet discards buffered flits and releases locks; no flit is emitted after reset deassertion until a new accept.

Decomposition:
- floo_pkg gains:
  - Constant function gen_conn_mask(route_algo_e, NumPorts) returning ConnMask.
  - Direction enum reuse (North, East, South, West, Eject).
  - Localparam typedef for lock owner index, $clog2(NumPorts) bits.
- Sub-module floo_vc_switch_out_stage (one per outport) contains legality check, lock FSM, FIFO (fifo_v3 instance, bypass when depth 0) and err flag.
- The top level contains only the VC muxes and the header/payload crossbar.

Test Plan (NumPorts=5, NumVCMax=4, OutFifoDepth=2, XY):
- Inport W VC2 payload 0xA5, hdr last=1, select W->E, ready_i=1 -> next cycle valid_o[E]=1, data_o[E] payload 0xA5, hdr copied exactly, err_o=0.
- 3-flit packet from W to L0 (last=0,0,1), then single-flit request from N to L0 in the middle of it -> N flit dropped, err_o[L0]=1, W flits arrive in order; after last, N flit accepted.
- ready_i[S]=0, push 3 flits into S -> ready_per_output_o[S]=0 after 2 accepts, third held. Then ready_i=1 -> 3 flits out in order, no duplicates.
- Select N->E (mask 0), zero select, and two-hot select -> all dropped, valid_o stays 0, err_o[E]=1. clr_err_i -> err_o=0 next cycle.
- Simultaneous push/pop at count 1 for 10 cycles -> count stays 1, throughput 1 flit/cycle, pointers wrap correctly.
- Assert rst_i while LOCKED with 2 flits buffered -> valid_o=0 and FSM IDLE immediately. After release, a new packet from any inport is accepted without error.
